// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Address/instruction widths, PC increment, reset vector and FSM encodings.
package fetch_unit_pkg;

    localparam int INSN_ADDR_WIDTH = 32;
    localparam int INSN_WIDTH      = 32;

    typedef logic [INSN_ADDR_WIDTH-1:0] InsnAddrPath;
    typedef logic [INSN_WIDTH-1:0]      InsnPath;
    typedef logic [1:0]                 FetchStatePath;

    localparam InsnAddrPath INSN_PC_INC       = 'd4;
    localparam InsnAddrPath INSN_RESET_VECTOR = '0;

    localparam FetchStatePath FETCH_ST_RESET = 2'd0;
    localparam FetchStatePath FETCH_ST_REQ   = 2'd1;
    localparam FetchStatePath FETCH_ST_WAIT  = 2'd2;
    localparam FetchStatePath FETCH_ST_HOLD  = 2'd3;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: instruction memory request/response, decode handshake
// and execute redirect. master = fetch unit, slave = its environment.
interface fetch_unit_if;
    import fetch_unit_pkg::*;

    logic        imemReq;
    InsnAddrPath imemAddr;
    logic        imemAck;
    logic        imemRespValid;
    InsnPath     imemRespInsn;
    logic        insnValid;
    InsnPath     insn;
    InsnAddrPath insnPC;
    logic        insnReady;
    logic        redirect;
    InsnAddrPath redirectPC;

    modport master (
        output imemReq, imemAddr, insnValid, insn, insnPC,
        input  imemAck, imemRespValid, imemRespInsn,
        input  insnReady, redirect, redirectPC
    );

    modport slave (
        input  imemReq, imemAddr, insnValid, insn, insnPC,
        output imemAck, imemRespValid, imemRespInsn,
        output insnReady, redirect, redirectPC
    );

endinterface

// File: rtl/fetch_unit_perf_counter.sv
// Fetch performance counters: decode handshakes and dropped instructions.
// Ports: clk, rst (sync, active high), fetchInc, dropInc, perfFetched, perfDiscarded.
module fetch_perf_counter (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetchInc,
    input  logic        dropInc,
    output logic [31:0] perfFetched,
    output logic [31:0] perfDiscarded
);

    always_ff @(posedge clk) begin
        if (rst) begin
            perfFetched   <= '0;
            perfDiscarded <= '0;
        end else begin
            if (fetchInc) perfFetched   <= perfFetched + 32'd1;
            if (dropInc)  perfDiscarded <= perfDiscarded + 32'd1;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, one outstanding imem request,
// holds the fetched instruction for decode and follows execute redirects.
// Ports: clk, rst (sync, active high), bus (fetch_unit_if.master).
// FETCH_PERF_CNT_EN adds perfFetched / perfDiscarded counter outputs.
module fetch_unit
    import fetch_unit_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    fetch_unit_if.master  bus
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]   perfFetched,
    output logic [31:0]   perfDiscarded
`endif
);

    FetchStatePath state, stateN;
    InsnAddrPath   pc, pcN;
    logic          discard, discardN;
    logic          validQ, validN;
    InsnPath       insnQ, insnN;
    InsnAddrPath   insnPCQ, insnPCN;
    logic          handshake;

    assign handshake = (state == FETCH_ST_HOLD) && validQ && bus.insnReady;

    always_comb begin
        stateN   = state;
        pcN      = pc;
        discardN = discard;
        validN   = validQ;
        insnN    = insnQ;
        insnPCN  = insnPCQ;
        unique case (state)
            FETCH_ST_RESET: stateN = FETCH_ST_REQ;
            FETCH_ST_REQ: begin
                if (bus.redirect) pcN = bus.redirectPC;
                // A redirect racing the ack makes that request stale.
                if (bus.imemAck) begin
                    stateN   = FETCH_ST_WAIT;
                    discardN = bus.redirect;
                end
            end
            FETCH_ST_WAIT: begin
                if (bus.redirect) begin
                    pcN      = bus.redirectPC;
                    discardN = 1'b1;
                end
                if (bus.imemRespValid) begin
                    if (bus.redirect || discard) begin
                        discardN = 1'b0;
                        stateN   = FETCH_ST_REQ;
                    end else begin
                        insnN   = bus.imemRespInsn;
                        insnPCN = pc;
                        validN  = 1'b1;
                        stateN  = FETCH_ST_HOLD;
                    end
                end
            end
            FETCH_ST_HOLD: begin
                if (handshake || bus.redirect) begin
                    validN = 1'b0;
                    stateN = FETCH_ST_REQ;
                    pcN    = bus.redirect ? bus.redirectPC
                                          : pc + INSN_PC_INC;
                end
            end
            default: stateN = FETCH_ST_RESET;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= FETCH_ST_RESET;
            pc      <= INSN_RESET_VECTOR;
            discard <= 1'b0;
            validQ  <= 1'b0;
            insnQ   <= '0;
            insnPCQ <= '0;
        end else begin
            state   <= stateN;
            pc      <= pcN;
            discard <= discardN;
            validQ  <= validN;
            insnQ   <= insnN;
            insnPCQ <= insnPCN;
        end
    end

    assign bus.imemReq   = (state == FETCH_ST_REQ);
    assign bus.imemAddr  = pc;
    assign bus.insnValid = validQ;
    assign bus.insn      = insnQ;
    assign bus.insnPC    = insnPCQ;

`ifdef FETCH_PERF_CNT_EN
    logic dropEv;

    // Dropped: stale/raced response in WAIT, or held insn killed by redirect.
    assign dropEv = ((state == FETCH_ST_WAIT) && bus.imemRespValid &&
                     (bus.redirect || discard)) ||
                    ((state == FETCH_ST_HOLD) && bus.redirect && !handshake);

    fetch_perf_counter u_perf (
        .clk          (clk),
        .rst          (rst),
        .fetchInc     (handshake),
        .dropInc      (dropEv),
        .perfFetched  (perfFetched),
        .perfDiscarded(perfDiscarded)
    );
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit.
// Checks counters too when FETCH_PERF_CNT_EN is defined.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fetch_unit_if bus ();

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perfFetched, perfDiscarded;
`endif

    fetch_unit dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perfFetched  (perfFetched),
        .perfDiscarded(perfDiscarded)
`endif
    );

    int checks = 0;
    int fails  = 0;
    int expF   = 0;
    int expD   = 0;
    logic sawBad = 1'b0;

    always @(negedge clk)
        if (bus.insnValid && bus.insn == 32'hDEADBEEF) sawBad = 1'b1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fetchOne(input InsnPath data, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.imemReq) break;
            tick();
        end
        if (!bus.imemReq) return;
        bus.imemAck = 1'b1;
        tick();
        bus.imemAck       = 1'b0;
        bus.imemRespValid = 1'b1;
        bus.imemRespInsn  = data;
        tick();
        bus.imemRespValid = 1'b0;
        ok = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.imemAck = 0; bus.imemRespValid = 0; bus.imemRespInsn = '0;
        bus.insnReady = 0; bus.redirect = 0; bus.redirectPC = '0;
        tick(); tick();
        checks++;
        if (bus.imemReq !== 1'b0) begin
            fails++; $display("FAIL rst_req: got %b want 0", bus.imemReq);
        end
        checks++;
        if (bus.insnValid !== 1'b0) begin
            fails++; $display("FAIL rst_valid: got %b want 0", bus.insnValid);
        end
        checks++;
        if (bus.insn !== 32'h0 || bus.insnPC !== 32'h0) begin
            fails++;
            $display("FAIL rst_insn: got %h/%h want 0/0", bus.insn, bus.insnPC);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (bus.imemReq !== 1'b1 || bus.imemAddr !== 32'h0) begin
            fails++;
            $display("FAIL first_req: got %b/%h want 1/0", bus.imemReq, bus.imemAddr);
        end
    endtask

    task automatic test_sequential();
        bus.imemAck = 1'b1;
        tick();
        bus.imemAck = 1'b0;
        checks++;
        if (bus.imemReq !== 1'b0 || bus.insnValid !== 1'b0) begin
            fails++;
            $display("FAIL seq_wait: got req %b vld %b want 0 0", bus.imemReq, bus.insnValid);
        end
        bus.imemRespValid = 1'b1;
        bus.imemRespInsn  = 32'h11111111;
        tick();
        bus.imemRespValid = 1'b0;
        checks++;
        if (bus.insnValid !== 1'b1 || bus.insn !== 32'h11111111 || bus.insnPC !== 32'h0) begin
            fails++;
            $display("FAIL seq_insn0: got %b %h %h want 1 11111111 0",
                     bus.insnValid, bus.insn, bus.insnPC);
        end
        bus.insnReady = 1'b1;
        tick();
        bus.insnReady = 1'b0;
        expF++;
        checks++;
        if (bus.insnValid !== 1'b0 || bus.imemReq !== 1'b1 || bus.imemAddr !== 32'h4) begin
            fails++;
            $display("FAIL seq_req1: got vld %b req %b addr %h want 0 1 4",
                     bus.insnValid, bus.imemReq, bus.imemAddr);
        end
        bus.imemAck = 1'b1;
        tick();
        bus.imemAck = 1'b0;
        bus.imemRespValid = 1'b1;
        bus.imemRespInsn  = 32'h22222222;
        tick();
        bus.imemRespValid = 1'b0;
        checks++;
        if (bus.insnValid !== 1'b1 || bus.insn !== 32'h22222222 || bus.insnPC !== 32'h4) begin
            fails++;
            $display("FAIL seq_insn1: got %b %h %h want 1 22222222 4",
                     bus.insnValid, bus.insn, bus.insnPC);
        end
    endtask

    task automatic test_stall();
        bus.insnReady     = 1'b0;
        bus.imemRespValid = 1'b1;
        bus.imemRespInsn  = 32'hBAD0BAD0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (bus.insnValid !== 1'b1 || bus.insn !== 32'h22222222 ||
                bus.insnPC !== 32'h4 || bus.imemReq !== 1'b0 || bus.imemAddr !== 32'h4) begin
                fails++;
                $display("FAIL stall_%0d: got vld %b insn %h pc %h req %b addr %h",
                         i, bus.insnValid, bus.insn, bus.insnPC, bus.imemReq, bus.imemAddr);
            end
        end
        bus.imemRespValid = 1'b0;
        bus.insnReady = 1'b1;
        tick();
        bus.insnReady = 1'b0;
        expF++;
        checks++;
        if (bus.imemReq !== 1'b1 || bus.imemAddr !== 32'h8) begin
            fails++;
            $display("FAIL stall_next: got %b/%h want 1/8", bus.imemReq, bus.imemAddr);
        end
    endtask

    task automatic test_redirect_wait();
        logic ok;
        bus.imemAck = 1'b1;
        tick();
        bus.imemAck    = 1'b0;
        bus.redirect   = 1'b1;
        bus.redirectPC = 32'h100;
        tick();
        bus.redirect = 1'b0;
        checks++;
        if (bus.imemReq !== 1'b0 || bus.imemAddr !== 32'h100) begin
            fails++;
            $display("FAIL rw_wait: got %b/%h want 0/100", bus.imemReq, bus.imemAddr);
        end
        tick();
        tick();
        bus.imemRespValid = 1'b1;
        bus.imemRespInsn  = 32'hDEADBEEF;
        tick();
        bus.imemRespValid = 1'b0;
        expD++;
        checks++;
        if (bus.insnValid !== 1'b0 || bus.imemReq !== 1'b1 || bus.imemAddr !== 32'h100) begin
            fails++;
            $display("FAIL rw_drop: got vld %b req %b addr %h want 0 1 100",
                     bus.insnValid, bus.imemReq, bus.imemAddr);
        end
        fetchOne(32'h33333333, ok);
        checks++;
        if (ok !== 1'b1) begin
            fails++; $display("FAIL rw_timeout: got %b want 1", ok);
        end
        checks++;
        if (bus.insnPC !== 32'h100 || bus.insn !== 32'h33333333) begin
            fails++;
            $display("FAIL rw_insn: got %h/%h want 100/33333333", bus.insnPC, bus.insn);
        end
        checks++;
        if (sawBad !== 1'b0) begin
            fails++; $display("FAIL rw_stale_seen: got %b want 0", sawBad);
        end
        bus.insnReady = 1'b1;
        tick();
        bus.insnReady = 1'b0;
        expF++;
    endtask

    task automatic test_redirect_hold();
        logic ok;
        fetchOne(32'h44444444, ok);
        checks++;
        if (ok !== 1'b1 || bus.insnPC !== 32'h104) begin
            fails++; $display("FAIL rh_fetch: got %b/%h want 1/104", ok, bus.insnPC);
        end
        bus.insnReady  = 1'b1;
        bus.redirect   = 1'b1;
        bus.redirectPC = 32'h40;
        tick();
        bus.insnReady = 1'b0;
        bus.redirect  = 1'b0;
        expF++;
        checks++;
        if (bus.insnValid !== 1'b0 || bus.imemReq !== 1'b1 || bus.imemAddr !== 32'h40) begin
            fails++;
            $display("FAIL rh_hs: got vld %b req %b addr %h want 0 1 40",
                     bus.insnValid, bus.imemReq, bus.imemAddr);
        end
`ifdef FETCH_PERF_CNT_EN
        checks++;
        if (perfFetched !== 32'(expF) || perfDiscarded !== 32'(expD)) begin
            fails++;
            $display("FAIL rh_perf: got %0d/%0d want %0d/%0d",
                     perfFetched, perfDiscarded, expF, expD);
        end
`endif
        bus.redirect   = 1'b1;
        bus.redirectPC = 32'h80;
        tick();
        checks++;
        if (bus.imemReq !== 1'b1 || bus.imemAddr !== 32'h80) begin
            fails++;
            $display("FAIL rr_noack: got %b/%h want 1/80", bus.imemReq, bus.imemAddr);
        end
        bus.redirectPC = 32'hC0;
        bus.imemAck    = 1'b1;
        tick();
        bus.redirect = 1'b0;
        bus.imemAck  = 1'b0;
        bus.imemRespValid = 1'b1;
        bus.imemRespInsn  = 32'h55555555;
        tick();
        bus.imemRespValid = 1'b0;
        expD++;
        checks++;
        if (bus.insnValid !== 1'b0 || bus.imemReq !== 1'b1 || bus.imemAddr !== 32'hC0) begin
            fails++;
            $display("FAIL rr_ack: got vld %b req %b addr %h want 0 1 c0",
                     bus.insnValid, bus.imemReq, bus.imemAddr);
        end
        fetchOne(32'h66666666, ok);
        checks++;
        if (ok !== 1'b1 || bus.insnPC !== 32'hC0) begin
            fails++; $display("FAIL rh2_fetch: got %b/%h want 1/c0", ok, bus.insnPC);
        end
        bus.redirect   = 1'b1;
        bus.redirectPC = 32'hFFFFFFFC;
        tick();
        bus.redirect = 1'b0;
        expD++;
        checks++;
        if (bus.insnValid !== 1'b0 || bus.imemReq !== 1'b1 || bus.imemAddr !== 32'hFFFFFFFC) begin
            fails++;
            $display("FAIL rh_kill: got vld %b req %b addr %h want 0 1 fffffffc",
                     bus.insnValid, bus.imemReq, bus.imemAddr);
        end
    endtask

    task automatic test_wrap();
        logic ok;
        fetchOne(32'h77777777, ok);
        checks++;
        if (ok !== 1'b1 || bus.insnPC !== 32'hFFFFFFFC) begin
            fails++; $display("FAIL wrap_fetch: got %b/%h want 1/fffffffc", ok, bus.insnPC);
        end
        bus.insnReady = 1'b1;
        tick();
        bus.insnReady = 1'b0;
        expF++;
        checks++;
        if (bus.imemReq !== 1'b1 || bus.imemAddr !== 32'h0) begin
            fails++; $display("FAIL wrap_addr: got %b/%h want 1/0", bus.imemReq, bus.imemAddr);
        end
`ifdef FETCH_PERF_CNT_EN
        checks++;
        if (perfFetched !== 32'(expF) || perfDiscarded !== 32'(expD)) begin
            fails++;
            $display("FAIL wrap_perf: got %0d/%0d want %0d/%0d",
                     perfFetched, perfDiscarded, expF, expD);
        end
`endif
    endtask

    task automatic test_reset_mid();
        logic ok;
        fetchOne(32'h88888888, ok);
        bus.insnReady = 1'b1;
        tick();
        bus.insnReady = 1'b0;
        checks++;
        if (ok !== 1'b1 || bus.imemAddr !== 32'h4) begin
            fails++; $display("FAIL rm_pre: got %b/%h want 1/4", ok, bus.imemAddr);
        end
        bus.imemAck = 1'b1;
        tick();
        bus.imemAck = 1'b0;
        rst = 1'b1;
        tick();
        checks++;
        if (bus.imemReq !== 1'b0 || bus.insnValid !== 1'b0 || bus.imemAddr !== INSN_RESET_VECTOR) begin
            fails++;
            $display("FAIL rm_rst: got req %b vld %b addr %h want 0 0 0",
                     bus.imemReq, bus.insnValid, bus.imemAddr);
        end
        rst = 1'b0;
        bus.imemRespValid = 1'b1;
        bus.imemRespInsn  = 32'hBADBAD00;
        tick();
        bus.imemRespValid = 1'b0;
        tick();
        checks++;
        if (bus.insnValid !== 1'b0 || bus.imemReq !== 1'b1 || bus.imemAddr !== INSN_RESET_VECTOR) begin
            fails++;
            $display("FAIL rm_late: got vld %b req %b addr %h want 0 1 0",
                     bus.insnValid, bus.imemReq, bus.imemAddr);
        end
`ifdef FETCH_PERF_CNT_EN
        checks++;
        if (perfFetched !== 32'd0 || perfDiscarded !== 32'd0) begin
            fails++;
            $display("FAIL rm_perf: got %0d/%0d want 0/0", perfFetched, perfDiscarded);
        end
`endif
        fetchOne(32'h99999999, ok);
        checks++;
        if (ok !== 1'b1 || bus.insn !== 32'h99999999 || bus.insnPC !== 32'h0) begin
            fails++;
            $display("FAIL rm_refetch: got %b %h %h want 1 99999999 0", ok, bus.insn, bus.insnPC);
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_redirect_wait();
        test_redirect_hold();
        test_wrap();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage holding the architectural PC. Issues one instruction-memory request at a time, holds the returned instruction until decode accepts it, and advances the PC by `INSN_PC_INC`. When execute asserts a redirect, it loads the branch unit's computed next-PC and discards any stale in-flight fetch. It sits directly upstream of decode/execute and consumes the branch unit's `pcOut`.

## Interface
- Parameters: none. Widths come from `INSN_ADDR_WIDTH` and `INSN_WIDTH`, the reset PC from `INSN_RESET_VECTOR` (all in Types.v).
- clk  in  1  clock; single clock domain
- rst  in  1  synchronous, active-high reset
- imemReq  out  1  fetch request valid
- imemAddr  out  `INSN_ADDR_WIDTH`  fetch address; equals the current PC
- imemAck  in  1  memory accepted the request this cycle
- imemRespValid  in  1  instruction data returned this cycle
- imemRespInsn  in  `INSN_WIDTH`  returned instruction
- insnValid  out  1  registered instruction available to decode
- insn  out  `INSN_WIDTH`  held instruction
- insnPC  out  `INSN_ADDR_WIDTH`  address of the held instruction
- insnReady  in  1  decode consumes the instruction when `insnValid && insnReady`
- redirect  in  1  execute resolved a change of flow
- redirectPC  in  `INSN_ADDR_WIDTH`  target PC (branch unit `pcOut`)

## Operation
- States:
  - RESET: entered while `rst`. Goes to REQ next cycle.
  - REQ: `imemReq=1`. On `imemAck`, goes to WAIT.
  - WAIT: waiting for `imemRespValid`. On a response, latches `insn`, `insnPC=pc` and goes to HOLD.
  - HOLD: `insnValid=1`. On a handshake, `pc<=pc+INSN_PC_INC` (wraps modulo 2^`INSN_ADDR_WIDTH`) and goes to REQ.
- At most one outstanding request. `imemRespValid` outside WAIT is ignored.
- A discard flag marks the outstanding request as stale.
- Redirect has priority over sequential increment. It always sets `pc<=redirectPC`.
  - In REQ without ack: stays in REQ, and the new address is driven the next cycle.
  - In REQ with ack the same cycle: goes to WAIT with discard set.
  - In WAIT: sets discard. If a response arrives the same cycle, it is dropped. The last redirect wins.
  - In WAIT with discard set: the response is dropped, discard clears, and the state goes to REQ.
  - In HOLD: the held instruction is dropped (`insnValid=0` next cycle) and the state goes to REQ. If the handshake happens the same cycle, the instruction counts as consumed and the PC still takes `redirectPC`.
  - In RESET: the redirect is ignored.
- Reset values: `pc=INSN_RESET_VECTOR`, state RESET, `imemReq=0`, `insnValid=0`, `insn=0`, `insnPC=0`, discard=0.
- Reset mid-operation clears everything the next cycle. A later response from the aborted request arrives outside WAIT or before the first new request and is ignored.

## Timing
- All outputs except `imemAddr` are registered. `imemReq` is decoded from state, and `imemAddr=pc`.
- `imemReq` and `imemAddr` stay stable until `imemAck`, except when changed by a redirect.
- With a zero-wait memory (ack in the request cycle, response the next cycle): request at t, WAIT at t+1, `insnValid` at t+2. Peak throughput is one instruction per 3 cycles.
- A redirect at cycle t in HOLD gives `imemReq` with `imemAddr=redirectPC` at t+1.

## Configuration
- `FETCH_PERF_CNT_EN` defined: adds outputs `perfFetched` (32 bit, increments per decode handshake) and `perfDiscarded` (32 bit, increments per dropped response or dropped held instruction). Both clear on `rst` and wrap on overflow.
- Undefined: the ports and counters are absent. Functional behaviour is otherwise identical.

## Structure
- Types.v gets:
  - state encoding macros `FETCH_ST_RESET/REQ/WAIT/HOLD` and `FetchStatePath`
  - `INSN_RESET_VECTOR`
  - reuse of `InsnAddrPath`, `InsnPath` and `INSN_PC_INC`
- Single module. The optional counters go in one sub-module, `fetch_perf_counter`, instantiated under the macro.

## Test plan
- Reset then zero-wait memory returning 0x11111111, 0x22222222, with `insnReady=1`:
  - `imemAddr` = 0x0, then 0x4
  - `insnValid` on cycles 2 and 5 after reset release
  - `insnPC` = 0x0, then 0x4
- `insnReady=0` for 5 cycles in HOLD: `insnValid`, `insn` and `insnPC` stay stable, `imemReq=0`, PC not advanced.
- Redirect to 0x100 while in WAIT, with the response 0xDEADBEEF 3 cycles later: the response is dropped and the next request has `imemAddr=0x100`. `insnPC` reaches 0x100 with no 0xDEADBEEF ever visible.
- Redirect to 0x40 in the same cycle as a HOLD handshake: the consumed instruction counts once, `insnValid=0` next cycle, and the next request goes to 0x40, not PC+4.
- PC 0xFFFFFFFC consumed: the next `imemAddr` is 0x0 (wrap-around).
- Assert `rst` mid-WAIT, then return a late response: it is ignored, the fetch restarts at `INSN_RESET_VECTOR`, and with `FETCH_PERF_CNT_EN` both counters read 0.
